// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives the imem req/ack handshake, owns the PC and
// presents one registered instruction (plus its PC and opcode) to the control unit.
// A one-entry skid buffer absorbs a word that returns while the output is stalled.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out
);

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] pc_inc;
  logic        out_free;

  // Sequential PC wraps naturally at 32 bits.
  assign pc_inc   = pc_q + PcStep;
  // Output register may take a new word when empty or when downstream consumes it.
  assign out_free = !instr_valid || !stall;

  // Opcode is a NOP whenever no live instruction is presented.
  assign opcode = instr_valid ? instr[31:26] : 6'd0;

  // Fetch FSM, PC, skid buffer and output register; flush outranks everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      instr_valid  <= 1'b0;
      instr        <= 32'd0;
      pc_out       <= 32'd0;
    end else if (flush) begin
      pc_q        <= flush_pc;
      instr_valid <= 1'b0;
      case (state_q)
        StDiscard: begin
          // Already draining an old request; only retarget once it completes.
          if (imem_ack) begin
            state_q   <= StFetch;
            imem_addr <= flush_pc;
          end
        end
        StFetch: begin
          if (imem_req && !imem_ack) begin
            // A request can never be withdrawn: keep it up and drop its data later.
            state_q <= StDiscard;
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= flush_pc;
          end
        end
        default: begin
          // From HOLD the skid word dies with the redirect.
          state_q   <= StFetch;
          imem_req  <= 1'b1;
          imem_addr <= flush_pc;
        end
      endcase
    end else begin
      case (state_q)
        StFetch: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
            if (!stall) instr_valid <= 1'b0;
          end else if (imem_ack) begin
            pc_q <= pc_inc;
            if (out_free) begin
              instr       <= imem_rdata;
              pc_out      <= imem_addr;
              instr_valid <= 1'b1;
              imem_addr   <= pc_inc;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= imem_addr;
              imem_req     <= 1'b0;
              state_q      <= StHold;
            end
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            instr       <= skid_instr_q;
            pc_out      <= skid_pc_q;
            instr_valid <= 1'b1;
            imem_req    <= 1'b1;
            imem_addr   <= pc_q;
            state_q     <= StFetch;
          end
        end
        default: begin
          if (!stall) instr_valid <= 1'b0;
          // Response to the pre-flush request is thrown away.
          if (imem_ack) begin
            state_q   <= StFetch;
            imem_addr <= pc_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed per-cycle vectors, a transaction-level
// reference model checked every cycle, and hand-computed literal checkpoints.
module tb_instr_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;

  // Second instance exercising the PC wrap from the top of the address space.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_opcode;
  logic [31:0] w_pc_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RstPc), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .flush_pc(flush_pc), .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .pc_out(pc_out)
  );

  assign w_ack = w_req;

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(32'h2400_0000), .stall(1'b0), .flush(1'b0),
    .flush_pc(32'd0), .instr_valid(w_valid), .instr(w_instr), .opcode(w_opcode),
    .pc_out(w_pc_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Memory content: opcode = word index + 1 within a 64-word window, low bits = address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    op = a[7:2] + 6'd1;
    return {op, a[25:0]};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc = RstPc;
  logic        m_req = 1'b0;
  logic [31:0] m_addr = RstPc;
  logic        m_discard = 1'b0;
  logic [63:0] m_skid[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pcout = 32'd0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_pc = RstPc; m_req = 1'b0; m_addr = RstPc; m_discard = 1'b0;
      m_skid.delete(); m_valid = 1'b0; m_instr = 32'd0; m_pcout = 32'd0;
    end else if (flush) begin
      m_pc = flush_pc;
      m_valid = 1'b0;
      m_skid.delete();
      if (m_discard) begin
        if (imem_ack) begin m_discard = 1'b0; m_addr = flush_pc; end
      end else if (m_req && !imem_ack) begin
        m_discard = 1'b1;
      end else begin
        m_req = 1'b1; m_addr = flush_pc;
      end
    end else if (m_discard) begin
      if (!stall) m_valid = 1'b0;
      if (imem_ack) begin m_discard = 1'b0; m_addr = m_pc; end
    end else if (m_skid.size() != 0) begin
      if (!stall) begin
        {m_instr, m_pcout} = m_skid.pop_front();
        m_valid = 1'b1; m_req = 1'b1; m_addr = m_pc;
      end
    end else if (!m_req) begin
      m_req = 1'b1; m_addr = m_pc;
      if (!stall) m_valid = 1'b0;
    end else if (imem_ack) begin
      if (!m_valid || !stall) begin
        m_instr = imem_rdata; m_pcout = m_addr; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_addr = m_pc;
      end else begin
        m_skid.push_back({imem_rdata, m_addr});
        m_pc = m_pc + 32'd4; m_req = 1'b0;
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("opcode", {26'd0, opcode}, m_valid ? {26'd0, m_instr[31:26]} : 32'd0);
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("pc_out", pc_out, m_pcout);
    end
  end

  // One cycle of stimulus: drive at the falling edge, return at the next falling edge.
  task automatic step(input logic a, input logic s, input logic f, input logic [31:0] fp);
    imem_ack = a; stall = s; flush = f; flush_pc = fp;
    imem_rdata = mem_word(imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Back-to-back fetch.
    step(0, 0, 0, 0);
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    chk("wrap_c1_addr", w_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("c2_opcode", {26'd0, opcode}, 32'd1);
    chk("c2_pc_out", pc_out, 32'd0);
    chk("c2_addr", imem_addr, 32'd4);
    chk("wrap_c2_pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap_c2_addr", w_addr, 32'd0);
    step(1, 0, 0, 0);
    chk("c3_opcode", {26'd0, opcode}, 32'd2);
    chk("c3_pc_out", pc_out, 32'd4);
    chk("c3_addr", imem_addr, 32'd8);
    chk("wrap_c3_pc_out", w_pc_out, 32'd0);
    chk("wrap_c3_opcode", {26'd0, w_opcode}, 32'd9);

    // Slow memory: request at 8 held until the late ack.
    step(0, 0, 0, 0);
    chk("c4_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("c6_addr", imem_addr, 32'd8);
    chk("c6_req", {31'd0, imem_req}, 32'd1);
    step(1, 0, 0, 0);
    chk("c7_pc_out", pc_out, 32'd8);
    chk("c7_opcode", {26'd0, opcode}, 32'd3);
    step(0, 0, 0, 0);

    // Stall while valid, word lands in the skid buffer.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("c10_req", {31'd0, imem_req}, 32'd0);
    chk("c10_pc_out", pc_out, 32'd12);
    chk("c10_opcode", {26'd0, opcode}, 32'd4);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("c12_pc_out", pc_out, 32'd16);
    chk("c12_opcode", {26'd0, opcode}, 32'd5);
    chk("c12_addr", imem_addr, 32'd20);

    // Flush with a request outstanding.
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    chk("c14_valid", {31'd0, instr_valid}, 32'd0);
    chk("c14_addr", imem_addr, 32'd24);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("c16_valid", {31'd0, instr_valid}, 32'd0);
    chk("c16_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);
    chk("c17_pc_out", pc_out, 32'h100);

    // Flush coincident with ack and stall.
    step(1, 1, 1, 32'h200);
    chk("c18_valid", {31'd0, instr_valid}, 32'd0);
    chk("c18_addr", imem_addr, 32'h200);
    step(1, 0, 0, 0);
    chk("c19_pc_out", pc_out, 32'h200);

    // Flush out of HOLD, then a double flush while discarding.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h300);
    chk("c21_addr", imem_addr, 32'h300);
    chk("c21_req", {31'd0, imem_req}, 32'd1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h400);
    step(0, 0, 1, 32'h500);
    chk("c24_addr", imem_addr, 32'h304);
    step(1, 0, 0, 0);
    chk("c25_addr", imem_addr, 32'h500);
    step(1, 0, 0, 0);
    chk("c26_pc_out", pc_out, 32'h500);
    step(0, 1, 0, 0);
    chk("c27_valid", {31'd0, instr_valid}, 32'd1);

    // Asynchronous reset in the middle of a wait.
    #2 reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_addr", imem_addr, 32'd0);
    step(1, 0, 0, 0);
    chk("post_rst_opcode", {26'd0, opcode}, 32'd1);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
